// File: rtl/reorder_buffer.sv
// Reorder buffer: slots are reserved in program order, completed in any order,
// and popped in program order once the oldest slot holds its result.
module reorder_buffer #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 8,
  parameter int INDEX_WIDTH = $clog2(DEPTH)
) (
  input  logic                   clock,
  input  logic                   resetn,
  output logic                   full,
  output logic                   empty,
  input  logic                   reserve_enable,
  output logic [INDEX_WIDTH-1:0] reserve_index,
  input  logic                   complete_enable,
  input  logic [INDEX_WIDTH-1:0] complete_index,
  input  logic [WIDTH-1:0]       complete_data,
  output logic                   complete_error,
  input  logic                   read_enable,
  output logic                   read_valid,
  output logic [WIDTH-1:0]       read_data
);

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
      $error("reorder_buffer: DEPTH must be a power of two of at least 2");
    end
  endgenerate

  typedef logic [INDEX_WIDTH:0] ptr_t;

  ptr_t                   head;
  ptr_t                   tail;
  logic [DEPTH-1:0]       allocated;
  logic [DEPTH-1:0]       completed;
  logic [WIDTH-1:0]       mem [DEPTH];
  logic [INDEX_WIDTH-1:0] head_idx;
  logic [INDEX_WIDTH-1:0] tail_idx;
  logic                   complete_legal;
  logic                   do_reserve;
  logic                   do_complete;
  logic                   do_pop;

  assign head_idx = head[INDEX_WIDTH-1:0];
  assign tail_idx = tail[INDEX_WIDTH-1:0];

  // The extra MSB on each pointer separates a full ring from an empty one.
  assign empty = (head == tail);
  assign full  = (head_idx == tail_idx) && (head[INDEX_WIDTH] != tail[INDEX_WIDTH]);

  assign reserve_index  = tail_idx;
  assign complete_legal = allocated[complete_index] & ~completed[complete_index];
  assign complete_error = complete_enable & ~complete_legal;
  assign read_valid     = allocated[head_idx] & completed[head_idx];
  assign read_data      = mem[head_idx];

  // All three actions are qualified by pre-edge state, so they never target the same slot.
  assign do_reserve  = reserve_enable & ~full;
  assign do_complete = complete_enable & complete_legal;
  assign do_pop      = read_enable & read_valid;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      head      <= '0;
      tail      <= '0;
      allocated <= '0;
      completed <= '0;
    end else begin
      if (do_pop) begin
        head                <= head + ptr_t'(1);
        allocated[head_idx] <= 1'b0;
        completed[head_idx] <= 1'b0;
      end
      if (do_reserve) begin
        tail                <= tail + ptr_t'(1);
        allocated[tail_idx] <= 1'b1;
        completed[tail_idx] <= 1'b0;
      end
      if (do_complete) begin
        completed[complete_index] <= 1'b1;
      end
    end
  end

  // Result storage carries no reset; the completed flags qualify its contents.
  always_ff @(posedge clock) begin
    if (do_complete) begin
      mem[complete_index] <= complete_data;
    end
  end

endmodule
